cmp_conv_ctrl: RTL

CMP_CONV_CTRL -- requirements
Module: cmp_conv_ctrl

---
 rtl/cmp_conv_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/cmp_conv_ctrl.sv
// Ramp-compare ADC conversion controller.
// Averages 2^NAVG_LOG2 ramp samples, flags saturated ramps.
module cmp_conv_ctrl #(
    parameter int CNT_W     = 8,
    parameter int NAVG_LOG2 = 2,
    parameter int SETTLE    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             cmp,
    output logic             ramp_en,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] result,
    output logic             timeout
);

    localparam int ACC_W = CNT_W + NAVG_LOG2;
    localparam int IDX_W = (NAVG_LOG2 > 0) ? NAVG_LOG2 : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'((1 << NAVG_LOG2) - 1);
    localparam logic [8:0]       SETTLE_V = 9'(SETTLE);

    typedef enum logic [2:0] {
        S_IDLE, S_DISCH, S_RAMP, S_ACC, S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic             cmp_m_q, cmp_s_q;
    logic [7:0]       settle_q, settle_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cap_q, cap_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             tpend_q, tpend_d;
    logic [CNT_W-1:0] result_q, result_d;
    logic             timeout_q, timeout_d;
    logic [8:0]       settle_inc;

    // Two-flop synchronizer for the asynchronous comparator.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmp_m_q <= 1'b0;
            cmp_s_q <= 1'b0;
        end else begin
            cmp_m_q <= cmp;
            cmp_s_q <= cmp_m_q;
        end
    end

    // Next-state and output decode; abort overrides active states.
    always_comb begin
        state_d    = state_q;
        settle_d   = settle_q;
        cnt_d      = cnt_q;
        cap_d      = cap_q;
        acc_d      = acc_q;
        idx_d      = idx_q;
        tpend_d    = tpend_q;
        result_d   = result_q;
        timeout_d  = timeout_q;
        ramp_en    = 1'b0;
        done       = 1'b0;
        settle_inc = {1'b0, settle_q} + 9'd1;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_DISCH;
                    acc_d    = '0;
                    idx_d    = '0;
                    settle_d = '0;
                    tpend_d  = 1'b0;
                end
            end
            S_DISCH: begin
                if (settle_q != 8'hFF) settle_d = settle_inc[7:0];
                if (settle_inc >= SETTLE_V && !cmp_s_q) begin
                    state_d = S_RAMP;
                    cnt_d   = '0;
                end
            end
            S_RAMP: begin
                ramp_en = 1'b1;
                if (cmp_s_q) begin
                    cap_d   = cnt_q;
                    state_d = S_ACC;
                end else if (cnt_q == CNT_MAX) begin
                    cap_d   = CNT_MAX;
                    tpend_d = 1'b1;
                    state_d = S_ACC;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_ACC: begin
                acc_d = acc_q + ACC_W'(cap_q);
                idx_d = idx_q + IDX_W'(1);
                if (idx_q == IDX_LAST) begin
                    state_d = S_DONE;
                end else begin
                    state_d  = S_DISCH;
                    settle_d = '0;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                result_d  = acc_q[ACC_W-1:NAVG_LOG2];
                timeout_d = tpend_q;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (abort && (state_q == S_DISCH || state_q == S_RAMP
                      || state_q == S_ACC)) begin
            state_d = S_IDLE;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            settle_q  <= '0;
            cnt_q     <= '0;
            cap_q     <= '0;
            acc_q     <= '0;
            idx_q     <= '0;
            tpend_q   <= 1'b0;
            result_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            settle_q  <= settle_d;
            cnt_q     <= cnt_d;
            cap_q     <= cap_d;
            acc_q     <= acc_d;
            idx_q     <= idx_d;
            tpend_q   <= tpend_d;
            result_q  <= result_d;
            timeout_q <= timeout_d;
        end
    end

    assign busy    = (state_q != S_IDLE);
    assign result  = result_q;
    assign timeout = timeout_q;

endmodule
